// File: rtl/updown_sweep_ctrl.sv
// Sweep sequencer for the 8-bit up/down counter: ramp or ping-pong between latched bounds,
// repeated for a programmed number of passes, with start/busy/done/err handshake.
module updown_sweep_ctrl #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned PASS_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [WIDTH-1:0]  lo,
    input  logic [WIDTH-1:0]  hi,
    input  logic              mode,
    input  logic [PASS_W-1:0] passes,
    output logic [WIDTH-1:0]  count,
    output logic              dir_up,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {StIdle, StUp, StDown, StDone} state_e;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    count_q, count_d;
    logic [WIDTH-1:0]    lo_q, lo_d;
    logic [WIDTH-1:0]    hi_q, hi_d;
    logic                mode_q, mode_d;
    logic                endless_q, endless_d;
    logic [PASS_W-1:0]   remaining_q, remaining_d;
    logic                err_q, err_d;
    logic                pass_done;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        mode_d      = mode_q;
        endless_d   = endless_q;
        remaining_d = remaining_q;
        err_d       = 1'b0;
        pass_done   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (lo <= hi) begin
                        lo_d        = lo;
                        hi_d        = hi;
                        mode_d      = mode;
                        endless_d   = (passes == '0);
                        remaining_d = passes;
                        count_d     = lo;
                        state_d     = StUp;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StUp: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (count_q != hi_q) begin
                    count_d = count_q + 1'b1;
                end else if (mode_q && (hi_q != lo_q)) begin
                    state_d = StDown;
                    count_d = hi_q - 1'b1;
                end else begin
                    pass_done = 1'b1;
                end
            end
            StDown: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (count_q != lo_q) begin
                    count_d = count_q - 1'b1;
                end else begin
                    pass_done = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (pass_done) begin
            if (!endless_q && (remaining_q == PASS_W'(1))) begin
                state_d = StDone;
            end else begin
                if (!endless_q) begin
                    remaining_d = remaining_q - 1'b1;
                end
                state_d = StUp;
                // Ping-pong restarts at lo+1 since lo was just shown at the bottom turn.
                count_d = (mode_q && (lo_q != hi_q)) ? lo_q + 1'b1 : lo_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            count_q     <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
            mode_q      <= 1'b0;
            endless_q   <= 1'b0;
            remaining_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            mode_q      <= mode_d;
            endless_q   <= endless_d;
            remaining_q <= remaining_d;
            err_q       <= err_d;
        end
    end

    assign count  = count_q;
    assign dir_up = (state_q != StDown);
    assign busy   = (state_q == StUp) || (state_q == StDown);
    assign done   = (state_q == StDone);
    assign err    = err_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Scoreboard bench for updown_sweep_ctrl: stimulus pushes expected per-cycle outputs, a monitor
// pops and compares whenever the DUT shows busy, done or err.
module tb_updown_sweep_ctrl;
    localparam int W  = 8;
    localparam int PW = 4;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          start  = 1'b0;
    logic          abort  = 1'b0;
    logic          mode   = 1'b0;
    logic [W-1:0]  lo     = '0;
    logic [W-1:0]  hi     = '0;
    logic [PW-1:0] passes = '0;
    logic [W-1:0]  count;
    logic          dir_up, busy, done, err;

    updown_sweep_ctrl #(.WIDTH(W), .PASS_W(PW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .abort  (abort),
        .lo     (lo),
        .hi     (hi),
        .mode   (mode),
        .passes (passes),
        .count  (count),
        .dir_up (dir_up),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] count;
        logic         dir_up;
        logic         busy;
        logic         done;
        logic         err;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_count = '0;

    function automatic exp_t mk(int c, bit d, bit b, bit dn, bit e);
        exp_t r;
        r.count  = W'(c);
        r.dir_up = d;
        r.busy   = b;
        r.done   = dn;
        r.err    = e;
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: one expected entry per cycle the DUT presents busy, done or err.
    always @(negedge clk) begin
        if (rst_n && (busy || done || err)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got count=%0d dir_up=%b busy=%b done=%b err=%b expected no output",
                         count, dir_up, busy, done, err);
            end else begin
                mon_e = exp_q.pop_front();
                check("monitor{count,dir_up,busy,done,err}", 32'({count, dir_up, busy, done, err}),
                      32'(mon_e));
            end
        end
    end

    // Reference: build the sweep as lists of values per pass; passes==0 truncates at limit.
    task automatic push_sweep(int l, int h, bit m, int p, int limit);
        int n    = 0;
        int pass = 0;
        int last = l;
        while ((p == 0 && n < limit) || (p != 0 && pass < p)) begin
            int vals[$];
            bit dirs[$];
            if (!m || l == h) begin
                for (int v = (m ? l : l); v <= h; v++) begin
                    vals.push_back(v);
                    dirs.push_back(1'b1);
                end
            end else begin
                for (int v = (pass == 0 ? l : l + 1); v <= h; v++) begin
                    vals.push_back(v);
                    dirs.push_back(1'b1);
                end
                for (int v = h - 1; v >= l; v--) begin
                    vals.push_back(v);
                    dirs.push_back(1'b0);
                end
            end
            foreach (vals[i]) begin
                if (p == 0 && n >= limit) break;
                exp_q.push_back(mk(vals[i], dirs[i], 1'b1, 1'b0, 1'b0));
                last = vals[i];
                n++;
            end
            pass++;
        end
        if (p != 0) exp_q.push_back(mk(last, 1'b1, 1'b0, 1'b1, 1'b0));
        exp_count = W'(last);
    endtask

    task automatic push_err();
        exp_q.push_back(mk(int'(exp_count), 1'b1, 1'b0, 1'b0, 1'b1));
    endtask

    task automatic do_start(int l, int h, bit m, int p);
        lo     = W'(l);
        hi     = W'(h);
        mode   = m;
        passes = PW'(p);
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_drain(string name);
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 2000) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d entries left expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic idle_check(string name);
        check({name, "_count"}, 32'(count), 32'(exp_count));
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_done"}, 32'(done), 32'd0);
        check({name, "_err"}, 32'(err), 32'd0);
        check({name, "_dir_up"}, 32'(dir_up), 32'd1);
    endtask

    initial begin
        int l, h, p;
        bit m;

        #2;
        idle_check("reset");
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Ramp, two passes; a start mid-sweep must be ignored.
        push_sweep(3, 6, 1'b0, 2, 0);
        do_start(3, 6, 1'b0, 2);
        repeat (2) @(posedge clk);
        #1 lo = 8'd0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_drain("ramp");
        idle_check("ramp_end");

        push_sweep(250, 253, 1'b1, 1, 0);
        do_start(250, 253, 1'b1, 1);
        wait_drain("pingpong");
        idle_check("pingpong_end");

        push_sweep(255, 255, 1'b0, 3, 0);
        do_start(255, 255, 1'b0, 3);
        wait_drain("top_bound");
        idle_check("top_bound_end");

        push_err();
        do_start(9, 4, 1'b0, 1);
        wait_drain("reject");
        idle_check("reject_end");

        // Endless ping-pong, abort sampled on the edge after the 20th busy cycle.
        push_sweep(0, 2, 1'b1, 0, 20);
        do_start(0, 2, 1'b1, 0);
        repeat (19) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_drained", 32'(exp_q.size()), 32'd0);
        idle_check("abort");
        repeat (3) @(posedge clk);
        #1;
        idle_check("abort_hold");

        // Asynchronous reset while count shows 5.
        push_sweep(2, 9, 1'b0, 0, 4);
        do_start(2, 9, 1'b0, 1);
        repeat (3) @(posedge clk);
        #6 rst_n = 1'b0;
        #1;
        exp_count = '0;
        check("async_rst_count", 32'(count), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_dir_up", 32'(dir_up), 32'd1);
        check("async_rst_drained", 32'(exp_q.size()), 32'd0);
        #5 rst_n = 1'b1;
        push_sweep(1, 3, 1'b1, 2, 0);
        do_start(1, 3, 1'b1, 2);
        wait_drain("after_reset");
        idle_check("after_reset_end");

        for (int i = 0; i < 16; i++) begin
            l = ($urandom_range(0, 2) == 0) ? int'($urandom_range(248, 255))
                                            : int'($urandom_range(0, 255));
            if (l > 0 && $urandom_range(0, 4) == 0) begin
                h = int'($urandom_range(0, l - 1));
            end else begin
                h = l + int'($urandom_range(0, 5));
                if (h > 255) h = 255;
            end
            m = 1'($urandom_range(0, 1));
            p = int'($urandom_range(1, 3));
            if (l > h) push_err();
            else push_sweep(l, h, m, p, 0);
            do_start(l, h, m, p);
            wait_drain("random");
            idle_check("random_end");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got simulation still running expected finish");
        $fatal(1, "timeout");
    end

endmodule
